// File: rtl/writeback_stage.sv
// RV32I write-back stage: register-file write port, one-cycle forwarding register,
// and retired-instruction / retired-load counters.
module writeback_stage #(
    parameter int          CNT_W   = 32,
    parameter int unsigned CNT_SAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEM_WB_valid,
    input  logic [4:0]       MEM_WB_RD,
    input  logic             MEM_WB_regwrite_en,
    input  logic             MEM_WB_wb_sel,
    input  logic [31:0]      MEM_WB_ALU_OUT,
    input  logic [31:0]      MEM_WB_LOAD_ALU_OUT,
    input  logic             cnt_clr,
    output logic             WB_ID_regwrite,
    output logic [31:0]      WB_ID_WD,
    output logic [4:0]       WB_ID_RDW_addr,
    output logic             WB_FWD_valid,
    output logic [4:0]       WB_FWD_RD,
    output logic [31:0]      WB_FWD_data,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] load_count
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic regwrite_s;
    logic retire_inc_s;
    logic load_inc_s;

    // Next counter value honouring the wrap/saturate overflow mode.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] nxt;
        if ((CNT_SAT != 0) && (&cnt)) begin
            nxt = cnt;
        end else begin
            nxt = cnt + CNT_ONE;
        end
        return nxt;
    endfunction

    // Write-enable qualification: bubbles, x0 targets and reset suppress the write.
    always_comb begin
        regwrite_s = 1'b0;
        if (rst) begin
            regwrite_s = 1'b0;
        end else if (MEM_WB_valid && MEM_WB_regwrite_en && (MEM_WB_RD != 5'd0)) begin
            regwrite_s = 1'b1;
        end else begin
            regwrite_s = 1'b0;
        end
    end

    // Counter increment conditions; the destination register plays no part.
    always_comb begin
        retire_inc_s = MEM_WB_valid;
        load_inc_s   = MEM_WB_valid & MEM_WB_regwrite_en & MEM_WB_wb_sel;
    end

    // Zero-latency register-file write port.
    always_comb begin
        WB_ID_regwrite = regwrite_s;
        WB_ID_RDW_addr = MEM_WB_RD;
        if (MEM_WB_wb_sel) begin
            WB_ID_WD = MEM_WB_LOAD_ALU_OUT;
        end else begin
            WB_ID_WD = MEM_WB_ALU_OUT;
        end
    end

    // Forwarding register: valid tracks every edge, payload only loads on a real write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_FWD_valid <= 1'b0;
            WB_FWD_RD    <= 5'd0;
            WB_FWD_data  <= 32'd0;
        end else begin
            WB_FWD_valid <= regwrite_s;
            if (regwrite_s) begin
                WB_FWD_RD   <= WB_ID_RDW_addr;
                WB_FWD_data <= WB_ID_WD;
            end else begin
                WB_FWD_RD   <= WB_FWD_RD;
                WB_FWD_data <= WB_FWD_data;
            end
        end
    end

    // Retire counters; a clear wins over a same-edge increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_count <= CNT_ZERO;
            load_count    <= CNT_ZERO;
        end else if (cnt_clr) begin
            retired_count <= CNT_ZERO;
            load_count    <= CNT_ZERO;
        end else begin
            if (retire_inc_s) begin
                retired_count <= cnt_next(retired_count);
            end else begin
                retired_count <= retired_count;
            end
            if (load_inc_s) begin
                load_count <= cnt_next(load_count);
            end else begin
                load_count <= load_count;
            end
        end
    end

endmodule
